// File: rtl/axi_pack_conv_ax_mode_dispatch.sv
// axi_pack_conv_ax_mode_dispatch: in-order N-way SSR AX request dispatcher with drain-on-mode-switch
module axi_pack_conv_ax_mode_dispatch #(
    parameter int ReqWidth       = 64,
    parameter int NumPaths       = 3,
    parameter int QueueDepth     = 4,
    parameter int MaxOutstanding = 8,
    parameter bit DrainOnSwitch  = 1'b1,
    parameter int ModeWidth      = $clog2(NumPaths),
    parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [ReqWidth-1:0]          req_i,
    input  logic [ModeWidth-1:0]         req_mode_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    output logic [NumPaths*ReqWidth-1:0] path_req_o,
    output logic [NumPaths-1:0]          path_valid_o,
    input  logic [NumPaths-1:0]          path_ready_i,
    input  logic [NumPaths-1:0]          path_done_i,
    output logic [ModeWidth-1:0]         cur_mode_o,
    output logic                         draining_o,
    output logic                         err_o
);
    localparam int PtrWidth  = QueueDepth > 1 ? $clog2(QueueDepth) : 1;
    localparam int FillWidth = $clog2(QueueDepth + 1);
    localparam logic RUN   = 1'b0;
    localparam logic DRAIN = 1'b1;

    logic [ReqWidth-1:0]  mem_data [QueueDepth];
    logic [ModeWidth-1:0] mem_mode [QueueDepth];
    logic [PtrWidth-1:0]  wptr, rptr;
    logic [FillWidth-1:0] fill;
    logic [CntWidth-1:0]  cnt [NumPaths];
    logic [CntWidth-1:0]  cnt_m;
    logic [ModeWidth-1:0] head_mode;
    logic [ReqWidth-1:0]  head_data;
    logic [NumPaths-1:0]  inc, underflow;
    logic live, state, empty, full, push, pop, bad, busy, go_drain, dispatch, bad_pop;

    function automatic logic [PtrWidth-1:0] nxt(input logic [PtrWidth-1:0] p);
        return p == PtrWidth'(QueueDepth - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty       = fill == '0;
    assign full        = fill == FillWidth'(QueueDepth);
    assign req_ready_o = live & ~full;
    assign push        = req_valid_i & req_ready_o;
    assign head_mode   = mem_mode[rptr];
    assign head_data   = mem_data[rptr];
    assign path_req_o  = {NumPaths{head_data}};
    assign bad         = int'(head_mode) >= NumPaths;
    assign draining_o  = state;

    // cnt_m is the head path's counter; busy flags any other path still in flight
    always_comb begin
        busy  = 1'b0;
        cnt_m = '0;
        for (int k = 0; k < NumPaths; k++) begin
            if (ModeWidth'(k) == head_mode) cnt_m = cnt[k];
            else if (cnt[k] != '0) busy = 1'b1;
        end
    end

    assign go_drain = ~empty & ~bad & (state == RUN) & DrainOnSwitch & (head_mode != cur_mode_o) & busy;
    assign dispatch = ~empty & ~bad & (state == RUN) & ~go_drain & (cnt_m < CntWidth'(MaxOutstanding));
    assign bad_pop  = ~empty & bad;

    genvar k;
    for (k = 0; k < NumPaths; k++) begin : g_path
        assign path_valid_o[k] = dispatch & (head_mode == ModeWidth'(k));
        assign inc[k]          = path_valid_o[k] & path_ready_i[k];
        assign underflow[k]    = path_done_i[k] & ~inc[k] & (cnt[k] == '0);
    end

    assign pop = (|inc) | bad_pop;

    // FIFO payload storage; head is only read once written, so no reset needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wptr] <= req_i;
            mem_mode[wptr] <= req_mode_i;
        end
    end

    // FIFO pointers, fill level and the post-reset ready enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
            live <= 1'b0;
        end else begin
            live <= 1'b1;
            wptr <= push ? nxt(wptr) : wptr;
            rptr <= pop ? nxt(rptr) : rptr;
            fill <= fill + FillWidth'(push) - FillWidth'(pop);
        end
    end

    // per-path outstanding counters: handshake increments, done decrements, both cancel
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumPaths; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NumPaths; i++) begin
                if (inc[i] & ~path_done_i[i] & (cnt[i] != CntWidth'(MaxOutstanding))) cnt[i] <= cnt[i] + 1'b1;
                else if (path_done_i[i] & ~inc[i] & (cnt[i] != '0)) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // drain FSM, last dispatched mode and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= RUN;
            cur_mode_o <= '0;
            err_o      <= 1'b0;
        end else begin
            state      <= (state == RUN) ? go_drain : busy;
            cur_mode_o <= (|inc) ? head_mode : cur_mode_o;
            err_o      <= err_o | bad_pop | (|underflow);
        end
    end
endmodule

// File: tb/tb_axi_pack_conv_ax_mode_dispatch.sv
// tb_axi_pack_conv_ax_mode_dispatch: directed and random checks against a queue-based reference model
module tb_axi_pack_conv_ax_mode_dispatch;
    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic [63:0]  req_i = '0;
    logic [1:0]   req_mode_i = '0;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic [191:0] path_req_o;
    logic [2:0]   path_valid_o;
    logic [2:0]   path_ready_i = '0;
    logic [2:0]   path_done_i = '0;
    logic [1:0]   cur_mode_o;
    logic         draining_o;
    logic         err_o;

    axi_pack_conv_ax_mode_dispatch dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .req_mode_i(req_mode_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .path_req_o(path_req_o),
        .path_valid_o(path_valid_o), .path_ready_i(path_ready_i), .path_done_i(path_done_i),
        .cur_mode_o(cur_mode_o), .draining_o(draining_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [65:0] q[$];
    int  m_cnt[3];
    int  m_cur;
    bit  m_drain, m_err, m_live;
    logic [2:0] pv_seen;
    logic dr_seen, err_seen;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_cur = 0; m_drain = 0; m_err = 0; m_live = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        req_valid_i = 1'b1;
        path_done_i = '0;
        path_ready_i = '1;
        #1;
        check("rst_ready", req_ready_o, 0);
        check("rst_valid", path_valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_drain", draining_o, 0);
        check("rst_mode", cur_mode_o, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        req_valid_i = 1'b0;
        m_live = 1;
    endtask

    task automatic step(input logic v, input logic [1:0] mode_in, input logic [63:0] d,
                        input logic [2:0] rdy, input logic [2:0] dn);
        logic [2:0] e_pv, hs;
        bit bad, go, busy, e_ready;
        int m;
        @(negedge clk);
        req_valid_i = v; req_mode_i = mode_in; req_i = d; path_ready_i = rdy; path_done_i = dn;
        #1;
        e_pv = '0; bad = 0; go = 0; busy = 0; m = 0;
        if (q.size() > 0) begin
            m = int'(q[0][65:64]);
            bad = m >= 3;
            for (int k = 0; k < 3; k++) if (k != m && m_cnt[k] > 0) busy = 1;
            if (!m_drain && !bad) begin
                if (m != m_cur && busy) go = 1;
                else if (m_cnt[m] < 8) e_pv[m] = 1'b1;
            end
        end
        e_ready = m_live && q.size() < 4;
        check("ready", req_ready_o, e_ready);
        check("path_valid", path_valid_o, e_pv);
        if (q.size() > 0) check("payload", path_req_o, {3{q[0][63:0]}});
        check("cur_mode", cur_mode_o, m_cur);
        check("draining", draining_o, m_drain);
        check("err", err_o, m_err);
        pv_seen = path_valid_o; dr_seen = draining_o; err_seen = err_o;
        hs = e_pv & rdy;
        for (int k = 0; k < 3; k++) begin
            if (hs[k] && !dn[k]) m_cnt[k]++;
            else if (dn[k] && !hs[k]) begin
                if (m_cnt[k] == 0) m_err = 1;
                else m_cnt[k]--;
            end
        end
        if (q.size() > 0 && bad) m_err = 1;
        if (|hs) m_cur = m;
        if (q.size() > 0) m_drain = m_drain ? busy : go;
        if (|hs || (q.size() > 0 && bad)) void'(q.pop_front());
        if (v && e_ready) q.push_back({mode_in, d});
        m_live = 1;
    endtask

    task automatic idle(input logic [2:0] dn);
        step(1'b0, 2'd0, 64'd0, 3'b111, dn);
    endtask

    int hits;

    initial begin
        // reset with a pending request, then ready after release
        do_reset();
        idle(3'b000);
        check("t1_ready_after_release", req_ready_o, 1);

        // same-mode stream
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            step(i < 4, 2'd1, 64'h1000 + i, 3'b111, 3'b000);
            if (pv_seen == 3'b010) hits++;
            check("t2_no_drain", dr_seen, 0);
        end
        check("t2_dispatches", hits, 4);
        for (int i = 0; i < 4; i++) idle(3'b010);

        // mode switch forces drain of path 0
        step(1, 2'd0, 64'hA0, 3'b111, 3'b000);
        step(1, 2'd0, 64'hA1, 3'b111, 3'b000);
        idle(3'b000);
        step(1, 2'd2, 64'hB2, 3'b111, 3'b000);
        idle(3'b000);
        idle(3'b000);
        check("t3_drain", dr_seen, 1);
        check("t3_no_valid", pv_seen, 0);
        idle(3'b001);
        idle(3'b001);
        idle(3'b000);
        check("t3_return_no_valid", pv_seen, 0);
        idle(3'b000);
        check("t3_run", dr_seen, 0);
        check("t3_dispatch2", pv_seen, 3'b100);
        idle(3'b100);

        // outstanding cap
        hits = 0;
        for (int i = 0; i < 13; i++) begin
            step(i < 9, 2'd1, 64'hC00 + i, 3'b111, 3'b000);
            if (pv_seen == 3'b010) hits++;
        end
        check("t4_capped", hits, 8);
        idle(3'b010);
        check("t4_held", pv_seen, 0);
        idle(3'b000);
        check("t4_released", pv_seen, 3'b010);
        for (int i = 0; i < 8; i++) idle(3'b010);
        check("t4_clean", err_seen, 0);

        // done at zero count sets err
        do_reset();
        idle(3'b100);
        idle(3'b000);
        check("t5_done_err", err_seen, 1);
        idle(3'b100);
        idle(3'b000);
        check("t5_err_sticky", err_seen, 1);

        // bad mode popped without valid
        do_reset();
        step(1, 2'd3, 64'hBAD, 3'b111, 3'b000);
        idle(3'b000);
        check("t5_bad_no_valid", pv_seen, 0);
        check("t5_bad_ready", req_ready_o, 1);
        idle(3'b000);
        check("t5_bad_err", err_seen, 1);

        // handshake and done on path 0 together keep count at 3
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 2'd0, 64'hD0 + i, 3'b111, 3'b000);
        idle(3'b000);
        step(1, 2'd0, 64'hD9, 3'b111, 3'b000);
        idle(3'b001);
        check("t6_hs_done", pv_seen, 3'b001);
        for (int i = 0; i < 3; i++) idle(3'b001);
        idle(3'b000);
        check("t6_three_left", err_seen, 0);
        idle(3'b001);
        idle(3'b000);
        check("t6_underflow", err_seen, 1);

        // reset in the middle of a drain
        do_reset();
        step(1, 2'd0, 64'hE0, 3'b111, 3'b000);
        step(1, 2'd1, 64'hE1, 3'b111, 3'b000);
        idle(3'b000);
        idle(3'b000);
        check("t6_in_drain", dr_seen, 1);
        do_reset();
        idle(3'b000);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [1:0] md;
            logic [2:0] dn;
            if (i % 400 == 399) do_reset();
            md = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            dn = '0;
            for (int k = 0; k < 3; k++)
                dn[k] = (m_cnt[k] > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
            step($urandom_range(0, 1), md, {$urandom, $urandom}, 3'($urandom), dn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
